sphere_scan_intersect: RTL and testbench
========================================

# sphere_scan_intersect

Sequential ray-versus-scene intersector for the ray tracer. On `start` it scans a sphere table of `NUM_SPHERES` entries, tests one camera-origin ray against each sphere, and reports the nearest positive hit distance and the index of the sphere hit. It is the parametrised successor to the single-sphere combinational collision test:
- per-sphere radius;
- configurable fixed-point format and table depth;
- a multi-cycle iterative square root in place of a combinational one;
- nearest-hit tracking across the whole scene.

## Interface
Parameters:
- `WIDTH`, 64: total bits of a signed fixed-point real.
- `FRAC`, 32: fractional bits (1.0 = 2^FRAC). `WIDTH+FRAC` must be even.
- `NUM_SPHERES`, 8: table depth, ≥1.
- `IDX_W`, `$clog2(NUM_SPHERES)` (min 1): sphere index width.

Ports:
- `Clk`  in  1: the single clock. All state updates on its rising edge.
- `Reset`  in  1: synchronous, active-high.
- `start`  in  1: 1-cycle request. Ignored unless `busy`=0.
- `ray`  in  3×WIDTH: ray direction {x,y,z}, unit length, origin at (0,0,0). Sampled on accepted `start`.
- `sph_addr`  out  IDX_W: sphere table read address.
- `sph_center`  in  3×WIDTH: sphere centre. Valid exactly 1 cycle after `sph_addr` is presented (synchronous RAM).
- `sph_radsq`  in  WIDTH: radius², same timing as `sph_center`.
- `busy`  out  1: high from the cycle after accepted `start` until `done`.
- `done`  out  1: 1-cycle pulse when results are valid.
- `hit`  out  1: at least one accepted intersection.
- `hit_idx`  out  IDX_W: index of the nearest hit sphere.
- `t_hit`  out  WIDTH: nearest hit distance. 0 if `hit`=0.

`hit`, `hit_idx` and `t_hit` hold their values until the next accepted `start`.

## Operation
FSM states: IDLE, ADDR, READ, DOT, TEST, SQRT, UPDATE, FIN.

State transitions:
- **IDLE → ADDR** on `start`:
  - latch `ray`;
  - index=0;
  - `best_t` = max positive value;
  - clear `hit`.
- **ADDR:** drive `sph_addr`=index. → READ.
- **READ:** register `sph_center` and `sph_radsq`. → DOT.
- **DOT:** compute and register `v = ray·c` and `cc = c·c`. → TEST.
- **TEST:** compute `bsq = cc − v·v` and compare with `radsq`.
  - If `radsq > bsq` (strict): start sqrt of `disc = radsq − bsq`, → SQRT.
  - Otherwise the sphere is a miss, → next.
- **SQRT:** wait for sqrt done. → UPDATE.
- **UPDATE:** `t = v − sqrt`.
  - If `t > 0` and `t < best_t` (both strict): `best_t`=t, `hit_idx`=index, `hit`=1.
  - → next.
- **next:**
  - if index = NUM_SPHERES−1: → FIN;
  - else index+1, → ADDR.
- **FIN:**
  - `t_hit` = `hit` ? `best_t` : 0;
  - pulse `done`;
  - → IDLE.

Arithmetic rules:
- Fixed-point multiply is a full 2·WIDTH signed product, arithmetic-shifted right by FRAC, truncated to WIDTH. No rounding, no saturation. Overflow wraps; keeping scene coordinates in range is the caller's job.
- A dot product is the sum of three such products.
- `sqrt` returns floor(√disc) in the same format. It is computed as the integer square root of `disc << FRAC` (WIDTH+FRAC bits).

Boundary behaviour:
- **Ties:** strict `<`, so the lowest index wins.
- **Camera inside a sphere:** t ≤ 0, so the sphere is rejected. Far-side hits are never reported.
- **`start` while busy:** ignored. `ray` is not re-sampled.
- **`Reset` mid-scan:** FSM → IDLE, sqrt aborted. All outputs go to 0 the cycle after `Reset` is asserted.
- **NUM_SPHERES=1:** a single pass, then FIN.

## Timing
- Reset value of every output is 0: `busy`, `done`, `hit`, `hit_idx`, `t_hit`, `sph_addr`.
- S = (WIDTH+FRAC)/2 sqrt cycles, one result bit per cycle. S = 48 at defaults.
- Cycles per sphere:
  - miss: 4 (ADDR, READ, DOT, TEST);
  - candidate: 4 + S + 1.
- `done` asserts in FIN, one cycle after the last sphere's final state.
- Start-to-done latency: 1 + Σ(per-sphere cycles) + 1.
  - Defaults, all misses: 1 + 32 + 1 = 34 cycles after the `start` edge.
- `busy` falls in the same cycle that `done` pulses. `start` may be asserted in that cycle and is accepted.

## Configuration
- `SPHERE_SCAN_EARLY_REJECT_EN`:
  - **Defined:** in TEST, a sphere with `v ≤ 0` (centre behind or beside the camera) is treated as a miss without entering SQRT. Such a sphere costs 4 cycles.
  - **Undefined:** such a sphere runs through SQRT and is rejected at UPDATE by t ≤ 0.
- `hit`, `hit_idx` and `t_hit` are identical in both builds. Only latency differs.

## Structure
- A shared package `raytrace_pkg` holds:
  - the `fixed_real` and `vector` typedefs, parametrised by WIDTH;
  - the `ONE` constant (1 << FRAC);
  - the `fx_mul` function.
- One sub-module, `fixed_sqrt_iter`:
  - start/done handshake;
  - restoring bit-by-bit integer square root;
  - params WIDTH, FRAC;
  - synchronous reset that aborts the computation.
- The dot products, compare and FSM live in `sphere_scan_intersect`.

## Test plan
Defaults apply (FRAC=32, 1.0 = 2^32), ray (0,0,1) unless noted.
- **Single hit:** one sphere, centre (0,0,100), radsq 1024.
  - Expect `hit`=1, idx 0, `t_hit`=68.0.
  - `done` exactly 4+48+1+2 = 55 cycles after the `start` edge.
- **Nearest of two:** idx0 (0,0,100) r²1024; idx1 (0,0,50) r²100.
  - Expect idx 1, t=40.0.
- **Miss:** centre (100,0,100), r²1024 (bsq=10000).
  - Expect `hit`=0, t=0, latency 6.
- **Behind camera:** centre (0,0,−100), r²1024.
  - Expect `hit`=0 in both builds.
  - Latency 6 with `SPHERE_SCAN_EARLY_REJECT_EN`, 55 without.
- **Tie:** NUM_SPHERES=8, identical spheres (0,0,100) r²1024 at idx 2 and 5, all others misses.
  - Expect idx 2, t=68.0.
- **Reset mid-scan:** assert `Reset` during SQRT.
  - All outputs read 0 the next cycle.
  - A new `start` then returns correct results.

Source files
------------

// File: rtl/raytrace_pkg.sv
// Shared fixed-point types, the 1.0 constant and the truncating fixed-point multiply.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package raytrace_pkg;

    // Default real format; modules that take WIDTH/FRAC parameters build matching local types.
    localparam int FX_WIDTH = 64;
    localparam int FX_FRAC  = 32;

    // Widest real that fx_mul can handle exactly.
    localparam int FX_MAX_W = 128;

    typedef logic signed [FX_WIDTH-1:0] fixed_real;

    typedef struct packed {
        fixed_real x;
        fixed_real y;
        fixed_real z;
    } vector;

    localparam fixed_real ONE = fixed_real'(1) << FX_FRAC;

    typedef logic signed [FX_MAX_W-1:0]   fx_wide_t;
    typedef logic signed [2*FX_MAX_W-1:0] fx_prod_t;

    // Full signed product, arithmetic shift right by frac, then truncation to the operand width.
    // Callers sign-extend their operands in and keep the low WIDTH bits of the result, so the
    // wrap-on-overflow behaviour matches a native WIDTH-bit implementation.
    function automatic fx_wide_t fx_mul(input fx_wide_t a, input fx_wide_t b, input int unsigned frac);
        fx_prod_t p;
        p = fx_prod_t'(a) * fx_prod_t'(b);
        p = p >>> frac;
        return fx_wide_t'(p);
    endfunction

endpackage

// File: rtl/fixed_sqrt_iter.sv
// Restoring bit-serial integer square root of (radicand << FRAC), i.e. floor(sqrt) in fixed point.
// Latency: (WIDTH+FRAC)/2 cycles; the first result bit is produced on the start edge, done pulses with the final one.
// Backpressure: none; a new start restarts the computation, Reset aborts it. Requires (WIDTH+FRAC)/2 >= 2.
module fixed_sqrt_iter #(
    parameter int WIDTH = 64,
    parameter int FRAC  = 32
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        start,
    input  logic [WIDTH-1:0]            radicand,
    output logic                        done,
    output logic [(WIDTH+FRAC)/2-1:0]   root
);

    localparam int N_W   = WIDTH + FRAC;
    localparam int S     = N_W / 2;
    localparam int CNT_W = $clog2(S + 1);

    logic [S:0]       rem_q,  rem_d;
    logic [S-1:0]     root_q, root_d;
    logic [N_W-1:0]   n_q,    n_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             run_q,  run_d;
    logic             done_q, done_d;

    logic [S:0]       src_rem;
    logic [S-1:0]     src_root;
    logic [N_W-1:0]   src_n;
    logic [S+2:0]     shifted;
    logic [S+2:0]     trial;

    // One restoring step per cycle: bring down two radicand bits, try subtracting 4*root+1.
    always_comb begin
        src_rem  = rem_q;
        src_root = root_q;
        src_n    = n_q;
        if (start) begin
            src_rem  = '0;
            src_root = '0;
            src_n    = N_W'(radicand) << FRAC;
        end
        shifted = {src_rem, src_n[N_W-1 -: 2]};
        trial   = {1'b0, src_root, 2'b01};

        rem_d  = rem_q;
        root_d = root_q;
        n_d    = n_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;

        if (start || run_q) begin
            if (shifted >= trial) begin
                rem_d  = (S+1)'(shifted - trial);
                root_d = {src_root[S-2:0], 1'b1};
            end else begin
                rem_d  = (S+1)'(shifted);
                root_d = {src_root[S-2:0], 1'b0};
            end
            n_d = src_n << 2;
            if (start) begin
                cnt_d = CNT_W'(1);
                run_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(S - 1)) begin
                    run_d  = 1'b0;
                    done_d = 1'b1;
                end
            end
        end
    end

    // State registers; Reset abandons any computation in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rem_q  <= '0;
            root_q <= '0;
            n_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            root_q <= root_d;
            n_q    <= n_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign root = root_q;

endmodule

// File: rtl/sphere_scan_intersect.sv
// Scans a sphere table against one origin ray and reports the nearest positive hit (index and distance).
// Latency: 1 + sum(4 per miss, 4+S+1 per candidate) + 1 cycles from start to done; S = (WIDTH+FRAC)/2.
// Backpressure: start ignored while busy; optional SPHERE_SCAN_EARLY_REJECT_EN skips the sqrt for centres with v <= 0.
module sphere_scan_intersect
    import raytrace_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int FRAC        = 32,
    parameter int NUM_SPHERES = 8,
    parameter int IDX_W       = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [3*WIDTH-1:0]   ray,
    output logic [IDX_W-1:0]     sph_addr,
    input  logic [3*WIDTH-1:0]   sph_center,
    input  logic [WIDTH-1:0]     sph_radsq,
    output logic                 busy,
    output logic                 done,
    output logic                 hit,
    output logic [IDX_W-1:0]     hit_idx,
    output logic [WIDTH-1:0]     t_hit
);

    localparam int SQ_W = (WIDTH + FRAC) / 2;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_SPHERES - 1);
    localparam logic signed [WIDTH-1:0] T_MAX    = {1'b0, {(WIDTH-1){1'b1}}};

    typedef logic signed [WIDTH-1:0] real_t;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_READ, S_DOT, S_TEST, S_SQRT, S_UPDATE, S_FIN} state_t;

    function automatic real_t mulw(input real_t a, input real_t b);
        fx_wide_t r;
        r = fx_mul(fx_wide_t'(a), fx_wide_t'(b), FRAC);
        return real_t'(r);
    endfunction

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    real_t             ray_x_q, ray_y_q, ray_z_q, ray_x_d, ray_y_d, ray_z_d;
    real_t             cen_x_q, cen_y_q, cen_z_q, cen_x_d, cen_y_d, cen_z_d;
    real_t             radsq_q, radsq_d;
    real_t             v_q, v_d, cc_q, cc_d, best_t_q, best_t_d;
    logic              hit_q, hit_d, busy_q, busy_d, done_q, done_d;
    logic [IDX_W-1:0]  hit_idx_q, hit_idx_d, sph_addr_q, sph_addr_d;
    real_t             t_hit_q, t_hit_d;

    real_t             bsq, disc, root_ext, t_cand;
    logic              test_pass, sq_start, sq_done, advance;
    logic [SQ_W-1:0]   sq_root;

    // Miss distance squared, discriminant and candidate distance from the registered dot products.
    always_comb begin
        bsq       = cc_q - mulw(v_q, v_q);
        disc      = radsq_q - bsq;
        root_ext  = real_t'(sq_root);
        t_cand    = v_q - root_ext;
`ifdef SPHERE_SCAN_EARLY_REJECT_EN
        test_pass = (radsq_q > bsq) && (v_q > 0);
`else
        test_pass = (radsq_q > bsq);
`endif
        sq_start  = (state_q == S_TEST) && test_pass;
    end

    fixed_sqrt_iter #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sqrt (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (sq_start),
        .radicand (disc),
        .done     (sq_done),
        .root     (sq_root)
    );

    // Scan FSM next-state and datapath: one sphere at a time, nearest strictly-positive hit wins.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ray_x_d    = ray_x_q;
        ray_y_d    = ray_y_q;
        ray_z_d    = ray_z_q;
        cen_x_d    = cen_x_q;
        cen_y_d    = cen_y_q;
        cen_z_d    = cen_z_q;
        radsq_d    = radsq_q;
        v_d        = v_q;
        cc_d       = cc_q;
        best_t_d   = best_t_q;
        hit_d      = hit_q;
        hit_idx_d  = hit_idx_q;
        t_hit_d    = t_hit_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sph_addr_d = sph_addr_q;
        advance    = 1'b0;

        case (state_q)
            S_IDLE: if (start) begin
                ray_x_d    = ray[3*WIDTH-1 -: WIDTH];
                ray_y_d    = ray[2*WIDTH-1 -: WIDTH];
                ray_z_d    = ray[WIDTH-1:0];
                idx_d      = '0;
                sph_addr_d = '0;
                best_t_d   = T_MAX;
                hit_d      = 1'b0;
                hit_idx_d  = '0;
                t_hit_d    = '0;
                busy_d     = 1'b1;
                state_d    = S_ADDR;
            end
            S_ADDR:   state_d = S_READ;
            S_READ: begin
                cen_x_d = sph_center[3*WIDTH-1 -: WIDTH];
                cen_y_d = sph_center[2*WIDTH-1 -: WIDTH];
                cen_z_d = sph_center[WIDTH-1:0];
                radsq_d = sph_radsq;
                state_d = S_DOT;
            end
            S_DOT: begin
                v_d     = mulw(ray_x_q, cen_x_q) + mulw(ray_y_q, cen_y_q) + mulw(ray_z_q, cen_z_q);
                cc_d    = mulw(cen_x_q, cen_x_q) + mulw(cen_y_q, cen_y_q) + mulw(cen_z_q, cen_z_q);
                state_d = S_TEST;
            end
            S_TEST: begin
                if (test_pass) state_d = S_SQRT;
                else           advance = 1'b1;
            end
            S_SQRT:   if (sq_done) state_d = S_UPDATE;
            S_UPDATE: begin
                if ((t_cand > 0) && (t_cand < best_t_q)) begin
                    best_t_d  = t_cand;
                    hit_idx_d = idx_q;
                    hit_d     = 1'b1;
                end
                advance = 1'b1;
            end
            S_FIN: begin
                t_hit_d = hit_q ? best_t_q : '0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = S_FIN;
            end else begin
                idx_d      = idx_q + IDX_W'(1);
                sph_addr_d = idx_q + IDX_W'(1);
                state_d    = S_ADDR;
            end
        end
    end

    // All scan state and registered outputs; Reset returns everything to zero / IDLE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            ray_x_q    <= '0;
            ray_y_q    <= '0;
            ray_z_q    <= '0;
            cen_x_q    <= '0;
            cen_y_q    <= '0;
            cen_z_q    <= '0;
            radsq_q    <= '0;
            v_q        <= '0;
            cc_q       <= '0;
            best_t_q   <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            t_hit_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sph_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ray_x_q    <= ray_x_d;
            ray_y_q    <= ray_y_d;
            ray_z_q    <= ray_z_d;
            cen_x_q    <= cen_x_d;
            cen_y_q    <= cen_y_d;
            cen_z_q    <= cen_z_d;
            radsq_q    <= radsq_d;
            v_q        <= v_d;
            cc_q       <= cc_d;
            best_t_q   <= best_t_d;
            hit_q      <= hit_d;
            hit_idx_q  <= hit_idx_d;
            t_hit_q    <= t_hit_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sph_addr_q <= sph_addr_d;
        end
    end

    assign sph_addr = sph_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign hit      = hit_q;
    assign hit_idx  = hit_idx_q;
    assign t_hit    = t_hit_q;

endmodule

// File: tb/tb_sphere_scan_intersect.sv
// Directed scoreboard bench: a 1-sphere DUT and an 8-sphere DUT, each fed from a synchronous-RAM model.
// Latency is counted in clock edges from the edge that samples start up to the edge that raises done.
module tb_sphere_scan_intersect;

    localparam int W = 64;

`ifdef SPHERE_SCAN_EARLY_REJECT_EN
    localparam int LAT_BEHIND = 6;
`else
    localparam int LAT_BEHIND = 55;
`endif

    typedef struct {
        bit          hit;
        int          idx;
        logic [63:0] t;
        int          lat;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    longint cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    // ---------------- DUT with one sphere ----------------
    logic           start1;
    logic [3*W-1:0] ray1, cen1;
    logic [W-1:0]   rs1, t1;
    logic [0:0]     addr1, idx1;
    logic           busy1, done1, hit1;
    logic [3*W-1:0] tab1_c [2];
    logic [W-1:0]   tab1_r [2];

    sphere_scan_intersect #(.WIDTH(64), .FRAC(32), .NUM_SPHERES(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .start(start1), .ray(ray1), .sph_addr(addr1),
        .sph_center(cen1), .sph_radsq(rs1), .busy(busy1), .done(done1),
        .hit(hit1), .hit_idx(idx1), .t_hit(t1)
    );

    always @(posedge Clk) begin
        cen1 <= tab1_c[addr1];
        rs1  <= tab1_r[addr1];
    end

    // ---------------- DUT with eight spheres ----------------
    logic           start8;
    logic [3*W-1:0] ray8, cen8;
    logic [W-1:0]   rs8, t8;
    logic [2:0]     addr8, idx8;
    logic           busy8, done8, hit8;
    logic [3*W-1:0] tab8_c [8];
    logic [W-1:0]   tab8_r [8];

    sphere_scan_intersect #(.WIDTH(64), .FRAC(32), .NUM_SPHERES(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .start(start8), .ray(ray8), .sph_addr(addr8),
        .sph_center(cen8), .sph_radsq(rs8), .busy(busy8), .done(done8),
        .hit(hit8), .hit_idx(idx8), .t_hit(t8)
    );

    always @(posedge Clk) begin
        cen8 <= tab8_c[addr8];
        rs8  <= tab8_r[addr8];
    end

    // ---------------- helpers ----------------
    function automatic logic [63:0] fx(input longint v);
        return 64'(v) << 32;
    endfunction

    function automatic logic [191:0] vec(input longint x, input longint y, input longint z);
        return {fx(x), fx(y), fx(z)};
    endfunction

    function automatic exp_t mk(input bit h, input int i, input logic [63:0] t, input int lat);
        exp_t e;
        e.hit = h; e.idx = i; e.t = t; e.lat = lat;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    exp_t   q1[$], q8[$];
    exp_t   e1, e8;
    longint t0_1, t0_8;

    always @(negedge Clk) begin
        if (!Reset && done1) begin
            if (q1.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL dut1_unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_hit",  64'(hit1), 64'(e1.hit));
                if (e1.hit) chk("dut1_idx", 64'(idx1), 64'(e1.idx));
                chk("dut1_t",    t1, e1.t);
                chk("dut1_lat",  64'(cyc - t0_1), 64'(e1.lat));
                chk("dut1_busy_at_done", 64'(busy1), 64'(0));
            end
        end
    end

    always @(negedge Clk) begin
        if (!Reset && done8) begin
            if (q8.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL dut8_unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                e8 = q8.pop_front();
                chk("dut8_hit",  64'(hit8), 64'(e8.hit));
                if (e8.hit) chk("dut8_idx", 64'(idx8), 64'(e8.idx));
                chk("dut8_t",    t8, e8.t);
                chk("dut8_lat",  64'(cyc - t0_8), 64'(e8.lat));
                chk("dut8_busy_at_done", 64'(busy8), 64'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic go1(input logic [191:0] r, input logic [191:0] c, input longint rsq, input exp_t e);
        @(negedge Clk);
        tab1_c[0] = c;
        tab1_r[0] = fx(rsq);
        ray1      = r;
        start1    = 1'b1;
        t0_1      = cyc;
        q1.push_back(e);
        @(negedge Clk);
        start1    = 1'b0;
    endtask

    task automatic go8(input bit push, input exp_t e);
        @(negedge Clk);
        ray8   = vec(0, 0, 1);
        start8 = 1'b1;
        t0_8   = cyc;
        if (push) q8.push_back(e);
        @(negedge Clk);
        start8 = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q1.size() != 0 || q8.size() != 0) && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        if (q1.size() != 0 || q8.size() != 0) begin
            nvec++; nerr++;
            $display("FAIL %s_timeout: got %0d results still pending, expected 0", nm, q1.size() + q8.size());
            q1.delete();
            q8.delete();
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic set_misses8();
        for (int i = 0; i < 8; i++) begin
            tab8_c[i] = vec(100, 0, 100);
            tab8_r[i] = fx(1024);
        end
    endtask

    task automatic set_tie8();
        set_misses8();
        tab8_c[2] = vec(0, 0, 100);
        tab8_c[5] = vec(0, 0, 100);
    endtask

    task automatic chk_zero1(input string nm);
        chk({nm, "_busy"}, 64'(busy1), 0); chk({nm, "_done"}, 64'(done1), 0);
        chk({nm, "_hit"},  64'(hit1), 0);  chk({nm, "_idx"},  64'(idx1), 0);
        chk({nm, "_t"},    t1, 0);         chk({nm, "_addr"}, 64'(addr1), 0);
    endtask

    task automatic chk_zero8(input string nm);
        chk({nm, "_busy"}, 64'(busy8), 0); chk({nm, "_done"}, 64'(done8), 0);
        chk({nm, "_hit"},  64'(hit8), 0);  chk({nm, "_idx"},  64'(idx8), 0);
        chk({nm, "_t"},    t8, 0);         chk({nm, "_addr"}, 64'(addr8), 0);
    endtask

    initial begin
        int n;
        Reset  = 1'b1;
        start1 = 1'b0;
        start8 = 1'b0;
        ray1   = '0;
        ray8   = '0;
        tab1_c[0] = '0; tab1_c[1] = '0;
        tab1_r[0] = '0; tab1_r[1] = '0;
        set_misses8();

        repeat (3) @(posedge Clk);
        #1;
        chk_zero1("reset1");
        chk_zero8("reset8");
        @(negedge Clk);
        Reset = 1'b0;

        // Single hit; a second start mid-scan with another ray must be ignored.
        go1(vec(0, 0, 1), vec(0, 0, 100), 1024, mk(1, 0, fx(68), 55));
        repeat (10) @(negedge Clk);
        ray1   = vec(1, 0, 0);
        start1 = 1'b1;
        @(negedge Clk);
        start1 = 1'b0;
        drain("single_hit");

        // Clean miss, tangent (radsq == bsq), behind camera, camera inside sphere.
        go1(vec(0, 0, 1), vec(100, 0, 100), 1024, mk(0, 0, 64'd0, 6));
        drain("miss");
        go1(vec(0, 0, 1), vec(32, 0, 100), 1024, mk(0, 0, 64'd0, 6));
        drain("tangent");
        go1(vec(0, 0, 1), vec(0, 0, -100), 1024, mk(0, 0, 64'd0, LAT_BEHIND));
        drain("behind");
        go1(vec(0, 0, 1), vec(0, 0, 10), 400, mk(0, 0, 64'd0, 55));
        drain("inside");

        // Non-square discriminant: t = 10 - floor(sqrt(2) * 2^32) / 2^32.
        go1(vec(0, 0, 1), vec(0, 0, 10), 2, mk(1, 0, 64'd36875671961, 55));
        drain("frac_sqrt");

        // Ray along x.
        go1(vec(1, 0, 0), vec(100, 0, 0), 1024, mk(1, 0, fx(68), 55));
        drain("x_axis");

        // Nearest of two among eight: two candidates of 53 cycles, six misses of 4.
        set_misses8();
        tab8_c[0] = vec(0, 0, 100); tab8_r[0] = fx(1024);
        tab8_c[1] = vec(0, 0, 50);  tab8_r[1] = fx(100);
        go8(1'b1, mk(1, 1, fx(40), 132));
        drain("nearest");

        // Tie at idx 2 and 5: lowest index wins.
        set_tie8();
        go8(1'b1, mk(1, 2, fx(68), 132));
        drain("tie");

        // Reset while sphere 5 is in its sqrt, then a clean rerun.
        go8(1'b0, mk(0, 0, 64'd0, 0));
        n = 0;
        while (addr8 != 3'd5 && n < 400) begin
            @(negedge Clk);
            n++;
        end
        chk("reach_idx5", 64'(addr8), 64'd5);
        repeat (10) @(negedge Clk);
        chk("pre_reset_busy", 64'(busy8), 64'd1);
        chk("pre_reset_hit",  64'(hit8),  64'd1);
        chk("pre_reset_idx",  64'(idx8),  64'd2);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk_zero8("mid_reset8");
        @(negedge Clk);
        Reset = 1'b0;
        go8(1'b1, mk(1, 2, fx(68), 132));
        drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
